discharge_recipe_sequencer: RTL and testbench
=============================================

# discharge_recipe_sequencer

Sequences a multi-step EDM machining recipe into the discharge controller's parameter and start/stop handshake ports. It holds up to DEPTH steps, each with Ton, Toff, Ip, waveform and a target breakdown count. For each step it loads the parameters, starts machining, counts breakdowns, then stops and advances. It sits between the SPI command decoder and the SPI-side inputs of the discharge controller, and adds a no-breakdown watchdog.

## Interface
Parameters:
- DEPTH, 8, recipe steps; ADDR_W = $clog2(DEPTH)
- SETTLE_CYCLES, 16'd100, clk cycles waited after every parameter load and after every stop
- NO_BREAKDOWN_TIMEOUT, 32'd10_000_000, 100 ms without a breakdown edge while running → fault

Ports:
- clk  in  1  100 MHz clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  write one recipe step (ignored while busy)
- wr_addr  in  ADDR_W  step index
- wr_ton / wr_toff / wr_ip / wr_waveform  in  16 each  step parameters
- wr_count  in  16  breakdowns for the step; 0 is treated as 1
- num_steps  in  ADDR_W+1  steps to execute, 0..DEPTH; sampled on run_req
- run_req  in  1  single-cycle start pulse
- abort_req  in  1  single-cycle abort pulse
- is_breakdown  in  1  breakdown indicator from the discharge controller (synchronous)
- change_Ton_ack / change_Toff_ack / change_Ip_ack / change_waveform_ack  out  1 each  load pulses
- Ton_data_async / Toff_data_async / Ip_data_async / waveform_data_async  out  16 each  parameter data
- machine_start_ack_spi / machine_stop_ack_spi  out  1 each  start/stop pulses
- busy  out  1  high outside IDLE
- step_idx  out  ADDR_W  current step
- done  out  1  one-cycle pulse on normal completion
- fault  out  1  sticky watchdog flag; cleared by the next accepted run_req

## Operation
- The FSM has the states IDLE, LOAD, SETTLE_L, START, RUN, STOP, SETTLE_S and FINISH.
- **IDLE:** run_req with num_steps>0 clears fault, sets step_idx=0 and goes to LOAD. run_req with num_steps==0 goes to FINISH and issues no acks.
- **LOAD (1 cycle):** drive the four data buses from table[step_idx] and pulse all four change_*_ack high in the same cycle. Data buses hold their value until the next LOAD. Then go to SETTLE_L.
- **SETTLE_L:** count SETTLE_CYCLES, then go to START.
- **START (1 cycle):** pulse machine_start_ack_spi. Clear the breakdown counter and the watchdog. Then go to RUN.
- **RUN:** a rising edge of is_breakdown (registered previous value) increments a 16-bit breakdown counter and clears the watchdog.
  - When the counter reaches max(wr_count,1), go to STOP.
  - When the watchdog reaches NO_BREAKDOWN_TIMEOUT, set fault=1 and go to STOP with the terminate flag set.
- **STOP (1 cycle):** pulse machine_stop_ack_spi, then go to SETTLE_S.
- **SETTLE_S:** count SETTLE_CYCLES, then:
  - terminate flag set → IDLE, no done;
  - step_idx+1 < num_steps → increment step_idx and go to LOAD;
  - otherwise → FINISH.
- **FINISH (1 cycle):** pulse done, then go to IDLE.
- **abort_req** in any state other than IDLE, STOP or SETTLE_S sets the terminate flag and jumps to STOP. In STOP or SETTLE_S it only sets the terminate flag. In IDLE it is ignored.
- **Priorities, same cycle:**
  - abort over count-reached and over watchdog;
  - a breakdown edge over the watchdog (the watchdog is cleared, no fault);
  - run_req is ignored while busy;
  - wr_en is ignored while busy.
- Counters saturate and never wrap.

## Timing
- **Reset values:** all acks and pulses 0, all data buses 0, busy=0, step_idx=0, done=0, fault=0, FSM in IDLE. Table contents are 0.
- **Outputs:** all registered, no combinational path from input to output.
- **Normal step, with run_req high at cycle 0:**
  - busy=1 from cycle 1;
  - change_*_ack high at cycle 1, with data valid that cycle;
  - machine_start_ack_spi high at cycle SETTLE_CYCLES+2.
- **RUN to STOP:** machine_stop_ack_spi goes high 2 cycles after the is_breakdown rising edge that completes the count (1 cycle for edge detect, 1 cycle for the transition).
- **Step to step:** the next step's acks go high SETTLE_CYCLES+1 cycles after the stop pulse.
- **Completion:** done goes high SETTLE_CYCLES+1 cycles after the final stop pulse, and busy=0 on the following cycle.
- **Table write:** a write lands on the cycle after wr_en and is readable by LOAD one cycle later.

## Structure
- **Shared package:** the FSM state enum, DEPTH/ADDR_W defaults, the step record typedef (ton, toff, ip, waveform, count; 80 bits), and SETTLE_CYCLES/NO_BREAKDOWN_TIMEOUT defaults.
- **Sub-module `recipe_table`:** DEPTH×80-bit register file with synchronous write and registered read, addressed by step_idx.
- **Top level:** the FSM, counters and edge detector stay in the top level.

## Test plan
- **Single step:** write step0 = {Ton 20, Toff 50, Ip 30, wf 1, count 5}, num_steps=1, SETTLE_CYCLES=4, run_req.
  - Required: the four acks pulse together with data 20/50/30/1;
  - start pulse at cycle 6;
  - after 5 is_breakdown edges, a stop pulse;
  - done 5 cycles after the stop; fault=0.
- **Three steps:** counts 2/3/1 → three LOAD/START/STOP triplets; step_idx shows 0,1,2; exactly one done pulse.
- **Watchdog:** NO_BREAKDOWN_TIMEOUT=1000 and no breakdown after start → stop pulse follows, fault=1, no done, busy drops.
  - Then a new run_req clears fault.
- **Abort:** abort_req in RUN → stop pulse 1 cycle later, then IDLE after settle with no done. Abort in the same cycle as the count completes → still a single stop pulse and no done.
- **Edges:**
  - num_steps=0 → done the next cycle with no acks;
  - wr_count=0 → step ends after 1 breakdown;
  - run_req and wr_en while busy are ignored (table unchanged);
  - rst_n asserted in RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/discharge_recipe_sequencer_pkg.sv
// Shared types and defaults for the discharge recipe sequencer.
package discharge_recipe_sequencer_pkg;

   localparam int unsigned DEPTH_DEF  = 8;
   localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned WD_W       = 32;

   localparam logic [15:0] SETTLE_CYCLES_DEF        = 16'd100;
   localparam logic [31:0] NO_BREAKDOWN_TIMEOUT_DEF = 32'd10_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE_L,
      ST_START,
      ST_RUN,
      ST_STOP,
      ST_SETTLE_S,
      ST_FINISH
   } state_e;

   // One recipe step, 80 bits.
   typedef struct packed {
      logic [DATA_W-1:0] ton;
      logic [DATA_W-1:0] toff;
      logic [DATA_W-1:0] ip;
      logic [DATA_W-1:0] waveform;
      logic [CNT_W-1:0]  count;
   } step_t;

   // A programmed count of zero still needs one breakdown to finish the step.
   function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
      return (c == '0) ? CNT_W'(1) : c;
   endfunction

endpackage

// File: rtl/discharge_recipe_sequencer_if.sv
// Parameter/start/stop handshake toward the discharge controller.
interface discharge_recipe_sequencer_if;
   import discharge_recipe_sequencer_pkg::*;

   logic              change_Ton_ack;
   logic              change_Toff_ack;
   logic              change_Ip_ack;
   logic              change_waveform_ack;
   logic [DATA_W-1:0] Ton_data_async;
   logic [DATA_W-1:0] Toff_data_async;
   logic [DATA_W-1:0] Ip_data_async;
   logic [DATA_W-1:0] waveform_data_async;
   logic              machine_start_ack_spi;
   logic              machine_stop_ack_spi;
   logic              is_breakdown;

   modport master (
      output change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
      output Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
      output machine_start_ack_spi, machine_stop_ack_spi,
      input  is_breakdown
   );

   modport slave (
      input  change_Ton_ack, change_Toff_ack, change_Ip_ack, change_waveform_ack,
      input  Ton_data_async, Toff_data_async, Ip_data_async, waveform_data_async,
      input  machine_start_ack_spi, machine_stop_ack_spi,
      output is_breakdown
   );

endinterface

// File: rtl/discharge_recipe_sequencer_recipe_table.sv
// Recipe step storage: synchronous write, registered read that holds between loads.
module recipe_table
   import discharge_recipe_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  step_t                    wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output step_t                    rd_data
);

   step_t mem_q [DEPTH];
   step_t rd_data_q;
   step_t rd_data_d;

   // Read register only updates on a load so the parameter buses stay stable.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   // Storage and read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/discharge_recipe_sequencer.sv
// Steps an EDM recipe through the discharge controller's load/start/stop handshake.
module discharge_recipe_sequencer
   import discharge_recipe_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH                = DEPTH_DEF,
   parameter logic [15:0] SETTLE_CYCLES        = SETTLE_CYCLES_DEF,
   parameter logic [31:0] NO_BREAKDOWN_TIMEOUT = NO_BREAKDOWN_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_ton,
   input  logic [DATA_W-1:0]        wr_toff,
   input  logic [DATA_W-1:0]        wr_ip,
   input  logic [DATA_W-1:0]        wr_waveform,
   input  logic [CNT_W-1:0]         wr_count,
   input  logic [$clog2(DEPTH):0]   num_steps,
   input  logic                     run_req,
   input  logic                     abort_req,
   discharge_recipe_sequencer_if.master ctrl,
   output logic                     busy,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     done,
   output logic                     fault
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned NW     = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] step_idx_q, step_idx_d;
   logic [NW-1:0]     num_steps_q, num_steps_d;
   logic [15:0]       settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]  brk_cnt_q, brk_cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              term_q, term_d;
   logic              fault_q, fault_d;
   logic              brk_s_q, brk_s_d;
   logic              brk_prev_q, brk_prev_d;
   logic              ack_q, ack_d;
   logic              start_q, start_d;
   logic              stop_q, stop_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              brk_edge_c;
   logic              settle_done_c;
   logic              more_steps_c;
   logic [CNT_W-1:0]  brk_inc_c;
   logic [WD_W-1:0]   wd_inc_c;
   logic [NW-1:0]     num_steps_clamp_c;
   logic              tbl_wr_en_c;
   step_t             wr_step_c;
   step_t             cur_step;

   assign tbl_wr_en_c = wr_en && (state_q == ST_IDLE);
   assign wr_step_c   = '{ton: wr_ton, toff: wr_toff, ip: wr_ip,
                          waveform: wr_waveform, count: wr_count};

   recipe_table #(.DEPTH(DEPTH)) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tbl_wr_en_c),
      .wr_addr (wr_addr),
      .wr_data (wr_step_c),
      .rd_en   (ack_d),
      .rd_addr (step_idx_d),
      .rd_data (cur_step)
   );

   // Saturating increments, edge detect and end-of-settle / more-steps decisions.
   always_comb begin
      brk_edge_c        = brk_s_q && !brk_prev_q;
      brk_inc_c         = (brk_cnt_q == '1) ? brk_cnt_q : brk_cnt_q + CNT_W'(1);
      wd_inc_c          = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
      settle_done_c     = ({1'b0, settle_cnt_q} + 17'd1) >= {1'b0, SETTLE_CYCLES};
      more_steps_c      = ({1'b0, step_idx_q} + NW'(1)) < num_steps_q;
      num_steps_clamp_c = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;
   end

   // Next-state, counters and registered-output decode.
   always_comb begin
      state_d      = state_q;
      step_idx_d   = step_idx_q;
      num_steps_d  = num_steps_q;
      settle_cnt_d = settle_cnt_q;
      brk_cnt_d    = brk_cnt_q;
      wd_d         = wd_q;
      term_d       = term_q;
      fault_d      = fault_q;
      brk_s_d      = ctrl.is_breakdown;
      brk_prev_d   = brk_s_q;

      case (state_q)
         ST_IDLE: begin
            if (run_req) begin
               fault_d     = 1'b0;
               term_d      = 1'b0;
               step_idx_d  = '0;
               num_steps_d = num_steps_clamp_c;
               state_d     = (num_steps == '0) ? ST_FINISH : ST_LOAD;
            end
         end
         ST_LOAD: begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE_L;
         end
         ST_SETTLE_L: begin
            if (settle_done_c) begin
               state_d = ST_START;
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end
         ST_START: begin
            brk_cnt_d = '0;
            wd_d      = '0;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (brk_edge_c) begin
               brk_cnt_d = brk_inc_c;
               wd_d      = '0;
               if (brk_inc_c >= eff_count(cur_step.count)) begin
                  state_d = ST_STOP;
               end
            end else begin
               wd_d = wd_inc_c;
               if (wd_inc_c >= NO_BREAKDOWN_TIMEOUT) begin
                  fault_d = 1'b1;
                  term_d  = 1'b1;
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE_S;
         end
         ST_SETTLE_S: begin
            if (settle_done_c) begin
               if (term_q) begin
                  state_d = ST_IDLE;
               end else if (more_steps_c) begin
                  step_idx_d = step_idx_q + ADDR_W'(1);
                  state_d    = ST_LOAD;
               end else begin
                  state_d = ST_FINISH;
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over count completion and watchdog; a pending stop only gets flagged.
      if (abort_req) begin
         case (state_q)
            ST_IDLE: ;
            ST_STOP, ST_SETTLE_S: term_d = 1'b1;
            default: begin
               term_d  = 1'b1;
               fault_d = fault_q;
               state_d = ST_STOP;
            end
         endcase
      end

      ack_d   = (state_d == ST_LOAD);
      start_d = (state_d == ST_START);
      stop_d  = (state_d == ST_STOP);
      done_d  = (state_d == ST_FINISH);
      busy_d  = (state_d != ST_IDLE);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         step_idx_q   <= '0;
         num_steps_q  <= '0;
         settle_cnt_q <= '0;
         brk_cnt_q    <= '0;
         wd_q         <= '0;
         term_q       <= 1'b0;
         fault_q      <= 1'b0;
         brk_s_q      <= 1'b0;
         brk_prev_q   <= 1'b0;
         ack_q        <= 1'b0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_idx_q   <= step_idx_d;
         num_steps_q  <= num_steps_d;
         settle_cnt_q <= settle_cnt_d;
         brk_cnt_q    <= brk_cnt_d;
         wd_q         <= wd_d;
         term_q       <= term_d;
         fault_q      <= fault_d;
         brk_s_q      <= brk_s_d;
         brk_prev_q   <= brk_prev_d;
         ack_q        <= ack_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign ctrl.change_Ton_ack        = ack_q;
   assign ctrl.change_Toff_ack       = ack_q;
   assign ctrl.change_Ip_ack         = ack_q;
   assign ctrl.change_waveform_ack   = ack_q;
   assign ctrl.Ton_data_async        = cur_step.ton;
   assign ctrl.Toff_data_async       = cur_step.toff;
   assign ctrl.Ip_data_async         = cur_step.ip;
   assign ctrl.waveform_data_async   = cur_step.waveform;
   assign ctrl.machine_start_ack_spi = start_q;
   assign ctrl.machine_stop_ack_spi  = stop_q;

   assign busy     = busy_q;
   assign step_idx = step_idx_q;
   assign done     = done_q;
   assign fault    = fault_q;

endmodule

// File: tb/tb_discharge_recipe_sequencer.sv
// Directed bench for discharge_recipe_sequencer with SETTLE_CYCLES=4, timeout 1000.
module tb_discharge_recipe_sequencer;
   import discharge_recipe_sequencer_pkg::*;

   localparam int unsigned AW = ADDR_W_DEF;
   localparam int unsigned NW = AW + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [15:0]   wr_ton = '0, wr_toff = '0, wr_ip = '0, wr_waveform = '0, wr_count = '0;
   logic [NW-1:0] num_steps = '0;
   logic          run_req = 1'b0;
   logic          abort_req = 1'b0;
   logic          busy, done, fault;
   logic [AW-1:0] step_idx;

   int checks = 0;
   int failures = 0;
   int n_ack = 0, n_start = 0, n_stop = 0, n_done = 0;

   discharge_recipe_sequencer_if ctrl();

   discharge_recipe_sequencer #(
      .DEPTH(DEPTH_DEF), .SETTLE_CYCLES(16'd4), .NO_BREAKDOWN_TIMEOUT(32'd1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_ton(wr_ton), .wr_toff(wr_toff), .wr_ip(wr_ip), .wr_waveform(wr_waveform),
      .wr_count(wr_count), .num_steps(num_steps), .run_req(run_req),
      .abort_req(abort_req), .ctrl(ctrl), .busy(busy), .step_idx(step_idx),
      .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (ctrl.change_Ton_ack)        n_ack++;
      if (ctrl.machine_start_ack_spi) n_start++;
      if (ctrl.machine_stop_ack_spi)  n_stop++;
      if (done)                       n_done++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_step(input logic [AW-1:0] a, input logic [15:0] ton, input logic [15:0] toff,
                             input logic [15:0] ip, input logic [15:0] wf, input logic [15:0] cnt);
      wr_addr = a; wr_ton = ton; wr_toff = toff; wr_ip = ip; wr_waveform = wf; wr_count = cnt;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic start_run(input int ns);
      num_steps = NW'(ns);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
   endtask

   task automatic pulse_brk(input int n);
      for (int i = 0; i < n; i++) begin
         ctrl.is_breakdown = 1'b1;
         tick();
         ctrl.is_breakdown = 1'b0;
         tick();
      end
   endtask

   // 0: load acks, 1: start, 2: stop, 3: done.
   task automatic wait_for(input int which, input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n <= limit && !ok; n++) begin
         case (which)
            0: ok = ctrl.change_Ton_ack;
            1: ok = ctrl.machine_start_ack_spi;
            2: ok = ctrl.machine_stop_ack_spi;
            default: ok = done;
         endcase
         if (!ok) tick();
      end
   endtask

   task automatic test_reset();
      ctrl.is_breakdown = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, fault, step_idx} !== '0) begin
         failures++; $display("FAIL reset_status: got %0h expected 0", {busy, done, fault, step_idx});
      end
      checks++;
      if ({ctrl.change_Ton_ack, ctrl.change_Toff_ack, ctrl.change_Ip_ack, ctrl.change_waveform_ack,
           ctrl.machine_start_ack_spi, ctrl.machine_stop_ack_spi} !== 6'b0) begin
         failures++; $display("FAIL reset_pulses: some ack/pulse high, expected all 0");
      end
      checks++;
      if ({ctrl.Ton_data_async, ctrl.Toff_data_async, ctrl.Ip_data_async, ctrl.waveform_data_async} !== 64'h0) begin
         failures++; $display("FAIL reset_data: got %0h expected 0",
            {ctrl.Ton_data_async, ctrl.Toff_data_async, ctrl.Ip_data_async, ctrl.waveform_data_async});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single_step();
      bit early;
      write_step(0, 16'd20, 16'd50, 16'd30, 16'd1, 16'd5);
      start_run(1);
      checks++;
      if ({ctrl.change_Ton_ack, ctrl.change_Toff_ack, ctrl.change_Ip_ack, ctrl.change_waveform_ack, busy} !== 5'b11111) begin
         failures++; $display("FAIL single_acks: got %b expected 11111",
            {ctrl.change_Ton_ack, ctrl.change_Toff_ack, ctrl.change_Ip_ack, ctrl.change_waveform_ack, busy});
      end
      checks++;
      if (ctrl.Ton_data_async !== 16'd20 || ctrl.Toff_data_async !== 16'd50 ||
          ctrl.Ip_data_async !== 16'd30 || ctrl.waveform_data_async !== 16'd1) begin
         failures++; $display("FAIL single_data: got %0d/%0d/%0d/%0d expected 20/50/30/1", ctrl.Ton_data_async,
            ctrl.Toff_data_async, ctrl.Ip_data_async, ctrl.waveform_data_async);
      end
      early = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         tick();
         if (ctrl.machine_start_ack_spi) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin failures++; $display("FAIL single_start_early: got 1 expected 0"); end
      tick();
      checks++;
      if (ctrl.machine_start_ack_spi !== 1'b1) begin
         failures++; $display("FAIL single_start_cycle6: got %b expected 1", ctrl.machine_start_ack_spi);
      end
      tick();
      pulse_brk(4);
      checks++;
      if (ctrl.machine_stop_ack_spi !== 1'b0) begin failures++; $display("FAIL single_stop_early: got 1 expected 0"); end
      pulse_brk(1);
      checks++;
      if (ctrl.machine_stop_ack_spi !== 1'b1) begin failures++; $display("FAIL single_stop: got 0 expected 1"); end
      early = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (done) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin failures++; $display("FAIL single_done_early: got 1 expected 0"); end
      tick();
      checks++;
      if (done !== 1'b1 || fault !== 1'b0) begin
         failures++; $display("FAIL single_done: got done=%b fault=%b expected 1/0", done, fault);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
   endtask

   task automatic test_three_steps();
      int cnts[3];
      int b_ack, b_start, b_stop, b_done;
      bit ok;
      cnts = '{2, 3, 1};
      for (int s = 0; s < 3; s++) begin
         write_step(AW'(s), 16'(s * 4 + 1), 16'(s * 4 + 2), 16'(s * 4 + 3), 16'(s * 4 + 4), 16'(cnts[s]));
      end
      b_ack = n_ack; b_start = n_start; b_stop = n_stop; b_done = n_done;
      start_run(3);
      for (int s = 0; s < 3; s++) begin
         wait_for(0, 30, ok);
         checks++;
         if (!ok || step_idx !== AW'(s) || ctrl.Ton_data_async !== 16'(s * 4 + 1) ||
             ctrl.waveform_data_async !== 16'(s * 4 + 4)) begin
            failures++; $display("FAIL three_load%0d: ok=%b idx=%0d ton=%0d wf=%0d expected idx=%0d ton=%0d wf=%0d",
               s, ok, step_idx, ctrl.Ton_data_async, ctrl.waveform_data_async, s, s * 4 + 1, s * 4 + 4);
         end
         wait_for(1, 30, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL three_start%0d: got none expected start", s); end
         tick();
         pulse_brk(cnts[s]);
         checks++;
         if (ctrl.machine_stop_ack_spi !== 1'b1) begin
            failures++; $display("FAIL three_stop%0d: got 0 expected 1", s);
         end
      end
      wait_for(3, 30, ok);
      tick(); tick();
      checks++;
      if (!ok || n_done - b_done != 1 || n_ack - b_ack != 3 || n_start - b_start != 3 || n_stop - b_stop != 3) begin
         failures++; $display("FAIL three_counts: done=%0d ack=%0d start=%0d stop=%0d expected 1/3/3/3",
            n_done - b_done, n_ack - b_ack, n_start - b_start, n_stop - b_stop);
      end
   endtask

   task automatic test_watchdog();
      int b_done;
      bit ok;
      write_step(0, 16'd7, 16'd8, 16'd9, 16'd2, 16'd5);
      b_done = n_done;
      start_run(1);
      wait_for(1, 30, ok);
      tick();
      wait_for(2, 1100, ok);
      checks++;
      if (!ok || fault !== 1'b1) begin
         failures++; $display("FAIL watchdog_trip: stop=%b fault=%b expected 1/1", ok, fault);
      end
      repeat (6) tick();
      checks++;
      if (busy !== 1'b0 || n_done != b_done) begin
         failures++; $display("FAIL watchdog_end: busy=%b dones=%0d expected 0/0", busy, n_done - b_done);
      end
      start_run(1);
      checks++;
      if (fault !== 1'b0) begin failures++; $display("FAIL watchdog_clear: got %b expected 0", fault); end
      wait_for(1, 30, ok);
      tick();
      pulse_brk(5);
      wait_for(3, 30, ok);
      tick();
   endtask

   task automatic test_abort();
      int b_done, b_stop;
      bit ok;
      write_step(0, 16'd3, 16'd3, 16'd3, 16'd3, 16'd5);
      b_done = n_done; b_stop = n_stop;
      start_run(1);
      wait_for(1, 30, ok);
      tick();
      abort_req = 1'b1;
      tick();
      abort_req = 1'b0;
      checks++;
      if (ctrl.machine_stop_ack_spi !== 1'b1) begin failures++; $display("FAIL abort_stop: got 0 expected 1"); end
      repeat (6) tick();
      checks++;
      if (busy !== 1'b0 || n_done != b_done || n_stop - b_stop != 1) begin
         failures++; $display("FAIL abort_end: busy=%b dones=%0d stops=%0d expected 0/0/1",
            busy, n_done - b_done, n_stop - b_stop);
      end
   endtask

   task automatic test_abort_same_cycle();
      int b_done, b_stop;
      bit ok;
      write_step(0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd1);
      b_done = n_done; b_stop = n_stop;
      start_run(1);
      wait_for(1, 30, ok);
      tick();
      ctrl.is_breakdown = 1'b1;
      tick();
      ctrl.is_breakdown = 1'b0;
      abort_req = 1'b1;
      tick();
      abort_req = 1'b0;
      checks++;
      if (ctrl.machine_stop_ack_spi !== 1'b1) begin failures++; $display("FAIL abort_same_stop: got 0 expected 1"); end
      repeat (7) tick();
      checks++;
      if (busy !== 1'b0 || n_done != b_done || n_stop - b_stop != 1) begin
         failures++; $display("FAIL abort_same_end: busy=%b dones=%0d stops=%0d expected 0/0/1",
            busy, n_done - b_done, n_stop - b_stop);
      end
   endtask

   task automatic test_zero_steps();
      int b_ack;
      b_ack = n_ack;
      start_run(0);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL zero_steps_done: got %b expected 1", done); end
      tick();
      checks++;
      if (busy !== 1'b0 || n_ack != b_ack) begin
         failures++; $display("FAIL zero_steps_acks: busy=%b acks=%0d expected 0/0", busy, n_ack - b_ack);
      end
   endtask

   task automatic test_zero_count();
      bit ok;
      write_step(0, 16'd42, 16'd1, 16'd1, 16'd1, 16'd0);
      start_run(1);
      checks++;
      if (ctrl.Ton_data_async !== 16'd42) begin
         failures++; $display("FAIL zero_count_load: got %0d expected 42", ctrl.Ton_data_async);
      end
      wait_for(1, 30, ok);
      tick();
      pulse_brk(1);
      checks++;
      if (ctrl.machine_stop_ack_spi !== 1'b1) begin failures++; $display("FAIL zero_count_stop: got 0 expected 1"); end
      wait_for(3, 30, ok);
      tick();
   endtask

   task automatic test_busy_ignore();
      int b_ack, b_done;
      bit ok;
      write_step(0, 16'd100, 16'd1, 16'd1, 16'd1, 16'd1);
      b_ack = n_ack; b_done = n_done;
      start_run(1);
      wr_addr = '0; wr_ton = 16'd777; wr_en = 1'b1;
      num_steps = NW'(3); run_req = 1'b1;
      tick();
      wr_en = 1'b0; run_req = 1'b0;
      wait_for(1, 30, ok);
      tick();
      pulse_brk(1);
      wait_for(3, 30, ok);
      tick(); tick();
      checks++;
      if (n_ack - b_ack != 1 || n_done - b_done != 1) begin
         failures++; $display("FAIL busy_run_req: acks=%0d dones=%0d expected 1/1", n_ack - b_ack, n_done - b_done);
      end
      start_run(1);
      checks++;
      if (ctrl.Ton_data_async !== 16'd100) begin
         failures++; $display("FAIL busy_wr_en: got ton=%0d expected 100", ctrl.Ton_data_async);
      end
      wait_for(1, 30, ok);
      tick();
      pulse_brk(1);
      wait_for(3, 30, ok);
      tick();
   endtask

   task automatic test_reset_in_run();
      bit ok;
      write_step(0, 16'd55, 16'd56, 16'd57, 16'd58, 16'd3);
      start_run(1);
      wait_for(1, 30, ok);
      tick();
      pulse_brk(1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, fault, step_idx, ctrl.change_Ton_ack, ctrl.machine_start_ack_spi,
           ctrl.machine_stop_ack_spi} !== '0 || ctrl.Ton_data_async !== 16'd0 ||
          ctrl.waveform_data_async !== 16'd0) begin
         failures++; $display("FAIL reset_in_run: busy=%b ton=%0d wf=%0d expected all 0",
            busy, ctrl.Ton_data_async, ctrl.waveform_data_async);
      end
      #3;
      rst_n = 1'b1;
      tick();
      start_run(1);
      checks++;
      if (ctrl.change_Ton_ack !== 1'b1 || ctrl.Ton_data_async !== 16'd0) begin
         failures++; $display("FAIL reset_table: ack=%b ton=%0d expected 1/0", ctrl.change_Ton_ack, ctrl.Ton_data_async);
      end
      wait_for(1, 30, ok);
      tick();
      pulse_brk(1);
      wait_for(3, 30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL reset_table_done: got none expected done"); end
      tick();
   endtask

   initial begin
      ctrl.is_breakdown = 1'b0;
      test_reset();
      test_single_step();
      test_three_steps();
      test_watchdog();
      test_abort();
      test_abort_same_cycle();
      test_zero_steps();
      test_zero_count();
      test_busy_ignore();
      test_reset_in_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
